// File: rtl/exe_mem_if.sv
// EXE->MEM pipeline bus: upstream valid/ready with payload, flush, downstream valid/ready
// with payload, and the stall counter.
interface exe_mem_if #(
    parameter int CTRL_W = 3,
    parameter int RW_W   = 5,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [RW_W-1:0]   in_rw;
    logic [DATA_W-1:0] in_result;
    logic [DATA_W-1:0] in_busb;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [RW_W-1:0]   out_rw;
    logic [DATA_W-1:0] out_result;
    logic [DATA_W-1:0] out_busb;
    logic [CNT_W-1:0]  stall_cnt;

    // Stage side
    modport slave (
        input  in_valid, in_ctrl, in_rw, in_result, in_busb, flush, out_ready,
        output in_ready, out_valid, out_ctrl, out_rw, out_result, out_busb, stall_cnt
    );

    // Environment side (EXE producer / MEM consumer)
    modport master (
        output in_valid, in_ctrl, in_rw, in_result, in_busb, flush, out_ready,
        input  in_ready, out_valid, out_ctrl, out_rw, out_result, out_busb, stall_cnt
    );
endinterface

// File: rtl/exe_mem_stage.sv
// Elastic EXE->MEM pipeline register with flush, bubble-gated control and a saturating
// stall counter. Define EXE_MEM_STAGE_SKID_EN for the two-entry skid build (registered in_ready).
module exe_mem_stage #(
    parameter int CTRL_W = 3,
    parameter int RW_W   = 5,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic      CLK,
    input  logic      reset,
    exe_mem_if.slave  bus
);

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [RW_W-1:0]   rw;
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] busb;
    } entry_t;

    entry_t           in_entry;
    entry_t           main_p1;
    logic             vld_p1;
    logic             in_ready;
    logic             accept;
    logic             consume;
    logic [CNT_W-1:0] stall_cnt_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign in_entry = '{ctrl: bus.in_ctrl, rw: bus.in_rw, result: bus.in_result, busb: bus.in_busb};

    // A flushed input is never taken, even though in_ready is left untouched.
    assign accept  = bus.in_valid && in_ready && !bus.flush;
    assign consume = vld_p1 && bus.out_ready;

`ifdef EXE_MEM_STAGE_SKID_EN
    entry_t skid_p1;
    logic   skid_vld_p1;

    // Ready depends only on the skid flop, so out_ready never reaches in_ready combinationally.
    assign in_ready = reset && !skid_vld_p1;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
            main_p1     <= '0;
            skid_p1     <= '0;
        end else if (bus.flush) begin
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
        end else if (!vld_p1 || consume) begin
            if (skid_vld_p1) begin
                // Skid full implies in_ready was low, so no input competes for main here.
                main_p1     <= skid_p1;
                vld_p1      <= 1'b1;
                skid_vld_p1 <= 1'b0;
            end else begin
                vld_p1 <= accept;
                if (accept) main_p1 <= in_entry;
            end
        end else if (accept) begin
            skid_p1     <= in_entry;
            skid_vld_p1 <= 1'b1;
        end
    end
`else
    assign in_ready = reset && (bus.out_ready || !vld_p1);

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            vld_p1  <= 1'b0;
            main_p1 <= '0;
        end else begin
            if (bus.flush)   vld_p1 <= 1'b0;
            else if (accept) vld_p1 <= 1'b1;
            else if (consume) vld_p1 <= 1'b0;
            if (accept) main_p1 <= in_entry;
        end
    end
`endif

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset)
            stall_cnt_q <= '0;
        else if (bus.in_valid && !in_ready && !bus.flush)
            stall_cnt_q <= sat_inc(stall_cnt_q);
    end

    // Control is gated for bubbles; data outputs simply show the last stored entry.
    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = vld_p1;
    assign bus.out_ctrl   = vld_p1 ? main_p1.ctrl : '0;
    assign bus.out_rw     = main_p1.rw;
    assign bus.out_result = main_p1.result;
    assign bus.out_busb   = main_p1.busb;
    assign bus.stall_cnt  = stall_cnt_q;

endmodule
